// File: rtl/uart_fsm_tx_pkg.sv
// Shared types and constants for the UART transmitter.
// The PARITY state is always declared; it is only reachable with UART_TX_PARITY_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam logic [31:0] FREQUENCY_DEF = 32'd50_000_000;
   localparam logic [31:0] SPEED_DEF     = 32'd9600;

   // Clock cycles per serial bit (integer divide, truncating).
   function automatic int unsigned calc_divider(input logic [31:0] freq, input logic [31:0] speed);
      return int'(freq / speed);
   endfunction

endpackage

// File: rtl/uart_fsm_tx_if.sv
// Byte handshake and serial line between the transmit controller and the UART transmitter.
interface uart_fsm_tx_if;
   logic [7:0] data;
   logic       req_i;
   logic       tx_o;
   logic       ready_o;

   modport master (output data, output req_i, input tx_o, input ready_o);
   modport slave  (input data, input req_i, output tx_o, output ready_o);
endinterface

// File: rtl/uart_fsm_tx_baud_gen.sv
// Bit-period counter: counts 0..DIVIDER-1 while enabled, pulses bit_end_o on the last cycle.
module uart_baud_gen #(
   parameter int unsigned DIVIDER = 5208
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   input  logic clr_i,
   output logic bit_end_o
);

   localparam int unsigned CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_fsm_tx.sv
// 8N1 UART transmitter FSM, LSB first, registered tx_o/ready_o.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_fsm_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] FREQUENCY = FREQUENCY_DEF,
   parameter logic [31:0] SPEED     = SPEED_DEF
) (
   input  logic          clk_i,
   input  logic          reset_i,
   uart_fsm_tx_if.slave  bus
);

   localparam int unsigned DIVIDER = calc_divider(FREQUENCY, SPEED);

   state_e     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       tx_q, tx_d;
   logic       ready_q, ready_d;
   logic       baud_en;
   logic       baud_clr;
   logic       bit_end;
`ifdef UART_TX_PARITY_EN
   logic       parity_q, parity_d;
`endif

   assign baud_en  = (state_q != IDLE) && (state_q != ARMED);
   assign baud_clr = (state_q == ARMED) && !bus.req_i;

   uart_baud_gen #(
      .DIVIDER (DIVIDER)
   ) u_baud_gen (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .en_i      (baud_en),
      .clr_i     (baud_clr),
      .bit_end_o (bit_end)
   );

   // Outputs are computed one cycle ahead so tx_o changes together with the state.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      ready_d   = ready_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req_i) begin
               state_d = ARMED;
               ready_d = 1'b0;
            end
         end
         ARMED: begin
            if (!bus.req_i) begin
               state_d   = START;
               shift_d   = bus.data;
               bit_cnt_d = 3'd0;
               tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^bus.data;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = parity_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  tx_d = shift_q[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               tx_d    = 1'b1;
               ready_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         shift_q   <= 8'h00;
         bit_cnt_q <= 3'd0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign bus.tx_o    = tx_q;
   assign bus.ready_o = ready_q;

endmodule

// File: tb/tb_uart_fsm_tx.sv
// Self-checking bench for uart_fsm_tx at DIVIDER=16 against a frame-level reference model.
module tb_uart_fsm_tx;

   localparam int D = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * D;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   uart_fsm_tx_if bus ();

   uart_fsm_tx #(
      .FREQUENCY (32'd16),
      .SPEED     (32'd1)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: serial symbol idx of the frame carrying byte b.
   function automatic logic exp_bit(input logic [7:0] b, input int idx);
      if (idx == 0)      return 1'b0;
      if (idx <= 8)      return b[idx-1];
      if (idx == NB - 1) return 1'b1;
      return ^b;
   endfunction

   // mode 0: plain, 1: req pulse during data bits, 2: data changed mid-frame
   task automatic send_frame(input logic [7:0] b, input int hold, input int mode);
      @(posedge clk); #1;
      bus.req_i = 1'b1;
      bus.data  = 8'($urandom);
      @(negedge clk);
      chk("ready_idle", 32'(bus.ready_o), 32'd1);
      @(posedge clk); #1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("ready_armed", 32'(bus.ready_o), 32'd0);
         chk("tx_armed", 32'(bus.tx_o), 32'd1);
         @(posedge clk); #1;
      end
      bus.req_i = 1'b0;
      bus.data  = b;
      @(posedge clk);
      for (int c = 0; c < FRAME; c++) begin
         @(negedge clk);
         chk($sformatf("tx_%02h_c%0d", b, c), 32'(bus.tx_o), 32'(exp_bit(b, c / D)));
         chk("ready_busy", 32'(bus.ready_o), 32'd0);
         @(posedge clk); #1;
         if (mode == 1 && c == 3 * D)     bus.req_i = 1'b1;
         if (mode == 1 && c == 3 * D + 4) bus.req_i = 1'b0;
         if (mode == 2 && c == 2 * D + 5) bus.data  = b ^ 8'hFF;
      end
      @(negedge clk);
      chk("ready_done", 32'(bus.ready_o), 32'd1);
      chk("tx_done", 32'(bus.tx_o), 32'd1);
      if (mode == 1) begin
         for (int k = 0; k < 2 * D; k++) begin
            @(negedge clk);
            chk("no_rearm_ready", 32'(bus.ready_o), 32'd1);
            chk("no_rearm_tx", 32'(bus.tx_o), 32'd1);
         end
      end
      $display("frame data=%02h hold=%0d mode=%0d checks=%0d errors=%0d", b, hold, mode, checks, errors);
   endtask

   initial begin
      int bad;
      bus.req_i = 1'b0;
      bus.data  = 8'h00;
      #1 reset = 1'b1;
      #1;
      chk("reset_tx", 32'(bus.tx_o), 32'd1);
      chk("reset_ready", 32'(bus.ready_o), 32'd1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      send_frame(8'hA5, 16, 0);
      send_frame(8'h00, $urandom_range(1, 4), 0);
      send_frame(8'hFF, $urandom_range(1, 4), 0);
      send_frame(8'h3C, $urandom_range(1, 8), 2);
      send_frame(8'h5A, $urandom_range(1, 8), 1);
      send_frame(8'h07, 2, 0);
      for (int i = 0; i < 5; i++) begin
         send_frame(8'($urandom), $urandom_range(1, 20), $urandom_range(0, 2));
      end

      // Reset in the middle of a frame aborts it and the line stays idle.
      @(posedge clk); #1;
      bus.req_i = 1'b1;
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      bus.data  = 8'h00;
      repeat (4 * D + 3) @(posedge clk);
      #3;
      chk("midframe_tx_low", 32'(bus.tx_o), 32'd0);
      reset = 1'b1;
      #1;
      chk("rst_mid_tx", 32'(bus.tx_o), 32'd1);
      chk("rst_mid_ready", 32'(bus.ready_o), 32'd1);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      bad = 0;
      for (int k = 0; k < 2 * D; k++) begin
         @(negedge clk);
         if (bus.tx_o !== 1'b1 || bus.ready_o !== 1'b1) bad++;
      end
      chk("rst_quiet", 32'(bad), 32'd0);
      $display("reset mid-frame checks=%0d errors=%0d", checks, errors);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
